mux_21_arbiter: RTL and testbench

MUX_21_ARBITER -- requirements
Module: mux_21_arbiter

---
 rtl/mux_21_arbiter.sv | 130 +++++++++++++
 tb/tb_mux_21_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux_21_arbiter.sv
// Round-robin arbiter that drives the select of a downstream 2:1 mux.
// Optional grant watchdog: define MUX_21_ARBITER_TIMEOUT_EN.
module mux_21_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  output logic       sel,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  if (MAX_HOLD < 2 || MAX_HOLD > 16) begin : g_bad_max_hold
    $error("mux_21_arbiter: MAX_HOLD must be in 2..16");
  end

  // NOTE: reset asserts asynchronously but is released through two flops, so
  // the state machine never leaves reset on an edge that is racing rst_n.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       arst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign arst_n = rst_sync_q[1];

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic [1:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic cur, in_gnt, release_ev, hold_expired, force_rel, arbitrate, winner;

  // With both requests up the source that was not granted last wins.
  function automatic logic pick(input logic [1:0] r, input logic l);
    return (r == 2'b11) ? ~l : r[1];
  endfunction

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    cur        = (state_q == GNT1);
    in_gnt     = (state_q != IDLE);
    release_ev = in_gnt && (done || !req[cur]);
    force_rel  = in_gnt && !release_ev && hold_expired;
    arbitrate  = !in_gnt || release_ev || force_rel;
    winner     = pick(req, last_q);
    if (arbitrate) begin
      if (req == 2'b00) begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end else begin
        state_d = winner ? GNT1 : GNT0;
        last_d  = winner;
        sel_d   = winner;
        gnt_d   = winner ? 2'b10 : 2'b01;
        busy_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

`ifdef MUX_21_ARBITER_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       grant_entry;

  assign grant_entry  = arbitrate && (req != 2'b00);
  // The MAX_HOLD-th edge of a grant sees the counter at MAX_HOLD-1.
  assign hold_expired = (cnt_q == 4'(MAX_HOLD - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = force_rel;
    if (grant_entry) cnt_d = 4'd0;
    else if (in_gnt) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q     <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_mux_21_arbiter.sv
// Directed self-checking bench for mux_21_arbiter (MAX_HOLD=4); expectations
// follow MUX_21_ARBITER_TIMEOUT_EN when it is defined.
module tb_mux_21_arbiter;

`ifdef MUX_21_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       done;
  logic       sel;
  logic [1:0] gnt;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  mux_21_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample 1 ns after the rising edge.
  task automatic cyc(input logic [1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] g, input logic s,
                            input logic b, input logic t);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_sel"}, 32'(sel), 32'(s));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  function automatic logic [1:0] onehot(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g;
    int   n;

    // Reset state and delayed first grant after reset release.
    rst_n = 1'b0;
    req   = 2'b00;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(2'b01, 1'b0);
    check("no_early_gnt", 32'(gnt), 32'(2'b00));
    repeat (3) cyc(2'b00, 1'b0);
    expect_out("idle_after_reset", 2'b00, 1'b0, 1'b0, 1'b0);

    // Single request on source 0, hold, then done with req=00.
    cyc(2'b01, 1'b0);
    expect_out("g0_entry", 2'b01, 1'b0, 1'b1, 1'b0);
    cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b0);
    expect_out("g0_hold", 2'b01, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 1'b1);
    expect_out("g0_release", 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b1);
    expect_out("done_in_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Single request on source 1; sel must hold 1 once idle again.
    cyc(2'b10, 1'b0);
    expect_out("g1_entry", 2'b10, 1'b1, 1'b1, 1'b0);
    cyc(2'b00, 1'b1);
    expect_out("idle_sel_hold", 2'b00, 1'b1, 1'b0, 1'b0);

    // Both requesting, done every third cycle: alternate with no idle gap.
    cyc(2'b11, 1'b0);
    expect_out("rr_first", 2'b01, 1'b0, 1'b1, 1'b0);
    g = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(2'b11, 1'b0);
      check("rr_hold_gnt", 32'(gnt), 32'(onehot(g)));
      cyc(2'b11, 1'b1);
      g = ~g;
      expect_out("rr_switch", onehot(g), g, 1'b1, 1'b0);
    end
    cyc(2'b00, 1'b1);
    expect_out("rr_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // GNT1 held while source 0 joins, until done.
    cyc(2'b10, 1'b0);
    expect_out("hold1_entry", 2'b10, 1'b1, 1'b1, 1'b0);
    cyc(2'b11, 1'b0);
    cyc(2'b11, 1'b0);
    expect_out("hold1_no_preempt", 2'b10, 1'b1, 1'b1, 1'b0);
    cyc(2'b11, 1'b1);
    expect_out("hold1_handover", 2'b01, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 1'b1);
    expect_out("hold1_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Watchdog: req=01 held, done=0.
    cyc(2'b01, 1'b0);
    expect_out("wd_entry", 2'b01, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(2'b01, 1'b0);
      expect_out("wd_cycle", 2'b01, 1'b0, 1'b1, TO_EN && (k % 4 == 0));
    end
    cyc(2'b00, 1'b1);
    expect_out("wd_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Genuine release on the MAX_HOLD-th edge wins over the watchdog.
    cyc(2'b01, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(2'b01, (k == 4));
      expect_out("wd_done_prec", 2'b01, 1'b0, 1'b1, TO_EN && (k == 8));
    end
    cyc(2'b00, 1'b1);

    // Asynchronous reset in the middle of a GNT1 cycle.
    cyc(2'b10, 1'b0);
    expect_out("mid_g1", 2'b10, 1'b1, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2'b11, 1'b0);
    check("post_reset_no_early", 32'(gnt), 32'(2'b00));
    n = 0;
    while (!busy && n < 4) begin
      cyc(2'b11, 1'b0);
      n++;
    end
    check("post_reset_grant_seen", 32'(busy), 32'(1'b1));
    expect_out("post_reset_src0", 2'b01, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
